// File: rtl/stopwatch_datapath.sv
// Stopwatch time base: 100 Hz tick divider, run/stop/clear FSM, cascaded
// hh:mm:ss.cc up/down counter and a lap snapshot that freezes the display.
module stopwatch_datapath #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_run_stop,
    input  logic        i_clear,
    input  logic        i_mode,
    input  logic        i_lap,
    output logic [23:0] o_time_data,
    output logic        o_running,
    output logic        o_lap_active
);

    localparam int DIV_COUNT = CLK_FREQ / TICK_HZ;
    localparam int DIV_W     = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_COUNT - 1);

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [6:0]       msec_reg, msec_next;
    logic [5:0]       sec_reg, sec_next;
    logic [5:0]       min_reg, min_next;
    logic [4:0]       hour_reg, hour_next;
    logic [23:0]      snap_reg, snap_next;
    logic             lap_reg, lap_next;
    logic             tick;
    logic [23:0]      live_time;

    assign tick      = (state_reg == ST_RUN) && (div_reg == DIV_MAX);
    assign live_time = {hour_reg, min_reg, sec_reg, msec_reg};

    always_comb begin
        state_next = ST_STOP;
        case (state_reg)
            ST_STOP: begin
                if (i_clear)
                    state_next = ST_CLEAR;
                else if (i_run_stop)
                    state_next = ST_RUN;
                else
                    state_next = ST_STOP;
            end
            ST_RUN:   state_next = i_run_stop ? ST_STOP : ST_RUN;
            ST_CLEAR: state_next = ST_STOP;
            default:  state_next = ST_STOP;
        endcase
    end

    // Divider only moves in RUN so a stop/resume keeps the partial tick.
    always_comb begin
        div_next = div_reg;
        if (state_reg == ST_CLEAR)
            div_next = '0;
        else if (state_reg == ST_RUN)
            div_next = (div_reg == DIV_MAX) ? '0 : div_reg + DIV_W'(1);
    end

    always_comb begin
        msec_next = msec_reg;
        sec_next  = sec_reg;
        min_next  = min_reg;
        hour_next = hour_reg;
        if (state_reg == ST_CLEAR) begin
            msec_next = '0;
            sec_next  = '0;
            min_next  = '0;
            hour_next = '0;
        end else if (tick && !i_mode) begin
            if (msec_reg == 7'd99) begin
                msec_next = '0;
                if (sec_reg == 6'd59) begin
                    sec_next = '0;
                    if (min_reg == 6'd59) begin
                        min_next  = '0;
                        hour_next = (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
                    end else begin
                        min_next = min_reg + 6'd1;
                    end
                end else begin
                    sec_next = sec_reg + 6'd1;
                end
            end else begin
                msec_next = msec_reg + 7'd1;
            end
        end else if (tick) begin
            // Down count: each field borrows from the next when it is at zero.
            if (msec_reg == 7'd0) begin
                msec_next = 7'd99;
                if (sec_reg == 6'd0) begin
                    sec_next = 6'd59;
                    if (min_reg == 6'd0) begin
                        min_next  = 6'd59;
                        hour_next = (hour_reg == 5'd0) ? 5'd23 : hour_reg - 5'd1;
                    end else begin
                        min_next = min_reg - 6'd1;
                    end
                end else begin
                    sec_next = sec_reg - 6'd1;
                end
            end else begin
                msec_next = msec_reg - 7'd1;
            end
        end
    end

    // Snapshot takes the pre-tick value on the edge that enters lap mode.
    always_comb begin
        lap_next  = lap_reg;
        snap_next = snap_reg;
        if (state_reg == ST_CLEAR) begin
            lap_next  = 1'b0;
            snap_next = '0;
        end else if ((state_reg == ST_STOP || state_reg == ST_RUN) && i_lap) begin
            lap_next = ~lap_reg;
            if (!lap_reg)
                snap_next = live_time;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_STOP;
            div_reg   <= '0;
            msec_reg  <= '0;
            sec_reg   <= '0;
            min_reg   <= '0;
            hour_reg  <= '0;
            snap_reg  <= '0;
            lap_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            msec_reg  <= msec_next;
            sec_reg   <= sec_next;
            min_reg   <= min_next;
            hour_reg  <= hour_next;
            snap_reg  <= snap_next;
            lap_reg   <= lap_next;
        end
    end

    assign o_time_data  = lap_reg ? snap_reg : live_time;
    assign o_running    = (state_reg == ST_RUN);
    assign o_lap_active = lap_reg;

endmodule

// File: tb/tb_stopwatch_datapath.sv
// Directed bench for stopwatch_datapath with a 10-clock tick period.
module tb_stopwatch_datapath;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_run_stop = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_mode = 1'b0;
    logic        i_lap = 1'b0;
    logic [23:0] o_time_data;
    logic        o_running;
    logic        o_lap_active;

    int tests = 0;
    int fails = 0;

    stopwatch_datapath #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_run_stop   (i_run_stop),
        .i_clear      (i_clear),
        .i_mode       (i_mode),
        .i_lap        (i_lap),
        .o_time_data  (o_time_data),
        .o_running    (o_running),
        .o_lap_active (o_lap_active)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the requested pulses high across exactly one rising edge.
    task automatic pulse(input logic rs, input logic clr, input logic lp);
        i_run_stop = rs;
        i_clear    = clr;
        i_lap      = lp;
        @(posedge clk);
        #1;
        i_run_stop = 1'b0;
        i_clear    = 1'b0;
        i_lap      = 1'b0;
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        tests++;
        assert (obs === exp) begin
            $display("[TB] %s: observed %h expected %h ok", tag, obs, exp);
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_time", o_time_data, 24'h000000);
        check("reset_run", {23'd0, o_running}, 24'd0);
        reset = 1'b0;
        wait_clk(1);
        check("reset_lap", {23'd0, o_lap_active}, 24'd0);

        // 2. up count for 100 ticks, then stop and hold
        pulse(1'b1, 1'b0, 1'b0);
        wait_clk(1000);
        check("run_1s", o_time_data, 24'h000080);
        check("running", {23'd0, o_running}, 24'd1);
        pulse(1'b1, 1'b0, 1'b0);
        wait_clk(50);
        check("stop_hold", o_time_data, 24'h000080);
        check("stopped", {23'd0, o_running}, 24'd0);

        // 3. clear, then down-count wrap and back up
        pulse(1'b0, 1'b1, 1'b0);
        wait_clk(1);
        check("clear_zero", o_time_data, 24'h000000);
        i_mode = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        wait_clk(9);
        check("pre_tick", o_time_data, 24'h000000);
        wait_clk(1);
        check("down_wrap", o_time_data, 24'hBF7DE3);
        i_mode = 1'b0;
        wait_clk(9);
        check("mode_hold", o_time_data, 24'hBF7DE3);
        wait_clk(1);
        check("up_wrap", o_time_data, 24'h000000);

        // 4. lap freeze at .05, release at .25
        wait_clk(50);
        check("pre_lap", o_time_data, 24'h000005);
        pulse(1'b0, 1'b0, 1'b1);
        check("lap_on", {23'd0, o_lap_active}, 24'd1);
        check("lap_snap", o_time_data, 24'h000005);
        wait_clk(199);
        check("lap_frozen", o_time_data, 24'h000005);
        pulse(1'b0, 1'b0, 1'b1);
        check("lap_off", {23'd0, o_lap_active}, 24'd0);
        check("lap_live", o_time_data, 24'h000019);

        // 5. clear beats run_stop in STOP; clear ignored in RUN
        pulse(1'b1, 1'b0, 1'b0);
        check("stop2", {23'd0, o_running}, 24'd0);
        pulse(1'b1, 1'b1, 1'b0);
        check("in_clear_run", {23'd0, o_running}, 24'd0);
        wait_clk(1);
        check("after_clear", o_time_data, 24'h000000);
        wait_clk(20);
        check("clear_won", {23'd0, o_running}, 24'd0);
        check("clear_stay", o_time_data, 24'h000000);
        pulse(1'b1, 1'b0, 1'b0);
        wait_clk(24);
        check("run_2t", o_time_data, 24'h000002);
        pulse(1'b0, 1'b1, 1'b0);
        check("clr_ign_run", {23'd0, o_running}, 24'd1);
        wait_clk(5);
        check("clr_ign_cnt", o_time_data, 24'h000003);

        // 6. partial tick survives stop/resume
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_clk(1);
        check("clear2", o_time_data, 24'h000000);
        pulse(1'b1, 1'b0, 1'b0);
        wait_clk(4);
        pulse(1'b1, 1'b0, 1'b0);
        wait_clk(20);
        check("partial_hold", o_time_data, 24'h000000);
        pulse(1'b1, 1'b0, 1'b0);
        wait_clk(4);
        check("resume_4", o_time_data, 24'h000000);
        wait_clk(1);
        check("resume_5", o_time_data, 24'h000001);

        // reset mid-run
        wait_clk(15);
        check("before_rst", o_time_data, 24'h000002);
        reset = 1'b1;
        wait_clk(1);
        check("mid_rst_time", o_time_data, 24'h000000);
        check("mid_rst_run", {23'd0, o_running}, 24'd0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
